multi_channel_pulse_generator: RTL and testbench

- Parametrised, multi-channel successor to the fixed-interval synchronous pulse generator.
- Each channel produces a programmable pulse train with period P, high width W and a mode:
  - continuous: runs until stopped;
  - burst: emits N periods, then stops.
- Configuration goes through a shared write port into per-channel shadow registers.
- Used as the timing/strobe source for downstream sampling, PWM and trigger logic.

---
 rtl/multi_channel_pulse_generator.sv | 170 +++++++++++++++++
 tb/tb_multi_channel_pulse_generator.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pulse_generator.sv
// Multi-channel programmable pulse generator: per-channel period/width/burst pulse trains.
// Latency: first pulse_out high cycle is the cycle right after the accepted start edge.
// Backpressure: none; enable=0 freezes every channel in place and forces pulse_out low.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   enable            global run enable; low freezes counters/state, start/stop ignored
//   cfg_we/cfg_ch     shadow-register write strobe and target channel (out-of-range ignored)
//   cfg_period/width  period P and high width W (P=0 behaves as 1)
//   cfg_burst_n       burst length N in periods (N=0 behaves as 1)
//   cfg_burst         0 continuous, 1 burst
//   start/stop        per-channel start/retrigger and abort; stop wins
//   pulse_out         registered pulse outputs
//   busy              channel in RUN
//   done              one-cycle strobe when a burst completes

module multi_channel_pulse_generator #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8,
    parameter int CH_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_we,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_period,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic [BURST_W-1:0] cfg_burst_n,
    input  logic               cfg_burst,
    input  logic [NUM_CH-1:0]  start,
    input  logic [NUM_CH-1:0]  stop,
    output logic [NUM_CH-1:0]  pulse_out,
    output logic [NUM_CH-1:0]  busy,
    output logic [NUM_CH-1:0]  done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0]   ONE_C = CNT_W'(1);
    localparam logic [BURST_W-1:0] ONE_B = BURST_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

        // Channel select only ever matches indices that exist, so an
        // out-of-range cfg_ch simply selects nothing.
        logic cfg_sel;
        assign cfg_sel = cfg_we && (cfg_ch == CH_W'(i));

        // Shadow configuration, written freely; never read by the counter directly.
        logic [CNT_W-1:0]   sh_period;
        logic [CNT_W-1:0]   sh_width;
        logic [BURST_W-1:0] sh_burst_n;
        logic               sh_burst;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sh_period  <= ONE_C;
                sh_width   <= '0;
                sh_burst_n <= ONE_B;
                sh_burst   <= 1'b0;
            end else if (cfg_sel) begin
                sh_period  <= cfg_period;
                sh_width   <= cfg_width;
                sh_burst_n <= cfg_burst_n;
                sh_burst   <= cfg_burst;
            end
        end

        // Zero period / burst length are folded to 1 on the way into the
        // active registers, so the counter never sees them.
        logic [CNT_W-1:0]   sh_period_norm;
        logic [BURST_W-1:0] sh_burst_n_norm;
        assign sh_period_norm  = (sh_period  == '0) ? ONE_C : sh_period;
        assign sh_burst_n_norm = (sh_burst_n == '0) ? ONE_B : sh_burst_n;

        // Active state
        state_t             state_q,      state_nx;
        logic [CNT_W-1:0]   cnt_q,        cnt_nx;
        logic [BURST_W-1:0] remaining_q,  remaining_nx;
        logic [CNT_W-1:0]   act_period_q, act_period_nx;
        logic [CNT_W-1:0]   act_width_q,  act_width_nx;
        logic               act_burst_q,  act_burst_nx;
        logic               pulse_q,      pulse_nx;
        logic               done_q,       done_nx;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q      <= IDLE;
                cnt_q        <= '0;
                remaining_q  <= ONE_B;
                act_period_q <= ONE_C;
                act_width_q  <= '0;
                act_burst_q  <= 1'b0;
                pulse_q      <= 1'b0;
                done_q       <= 1'b0;
            end else begin
                state_q      <= state_nx;
                cnt_q        <= cnt_nx;
                remaining_q  <= remaining_nx;
                act_period_q <= act_period_nx;
                act_width_q  <= act_width_nx;
                act_burst_q  <= act_burst_nx;
                pulse_q      <= pulse_nx;
                done_q       <= done_nx;
            end
        end

        logic period_end;
        assign period_end = (cnt_q == (act_period_q - ONE_C));

        always_comb begin
            state_nx      = state_q;
            cnt_nx        = cnt_q;
            remaining_nx  = remaining_q;
            act_period_nx = act_period_q;
            act_width_nx  = act_width_q;
            act_burst_nx  = act_burst_q;
            pulse_nx      = 1'b0;
            done_nx       = 1'b0;

            if (!enable) begin
                // Frozen: everything holds, output parked low.
            end else if (stop[i]) begin
                state_nx = IDLE;
            end else if (start[i]) begin
                // Start and retrigger are the same action: full config load.
                state_nx      = RUN;
                cnt_nx        = '0;
                act_period_nx = sh_period_norm;
                act_width_nx  = sh_width;
                act_burst_nx  = sh_burst;
                remaining_nx  = sh_burst_n_norm;
                pulse_nx      = (sh_width != '0);
            end else if (state_q == RUN) begin
                if (period_end) begin
                    cnt_nx = '0;
                    if (act_burst_q) begin
                        if (remaining_q == ONE_B) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end else begin
                            remaining_nx = remaining_q - ONE_B;
                            pulse_nx     = (act_width_q != '0);
                        end
                    end else begin
                        // Continuous trains pick up new P/W only here, so a
                        // period is never cut short or stretched mid-way.
                        act_period_nx = sh_period_norm;
                        act_width_nx  = sh_width;
                        pulse_nx      = (sh_width != '0);
                    end
                end else begin
                    // cnt_q < P-1 here, so the increment cannot wrap.
                    cnt_nx   = cnt_q + ONE_C;
                    pulse_nx = ((cnt_q + ONE_C) < act_width_q);
                end
            end
        end

        assign pulse_out[i] = pulse_q;
        assign busy[i]      = (state_q == RUN);
        assign done[i]      = done_q;
    end

endmodule

// File: tb/tb_multi_channel_pulse_generator.sv
// Testbench for multi_channel_pulse_generator: hand-derived vector tables,
// a reset sequence, then randomized traffic against a reference model.
// Three channels so that cfg_ch == NUM_CH is a reachable write target.

module tb_multi_channel_pulse_generator;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 16;
    localparam int BURST_W = 8;
    localparam int CH_W    = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               cfg_we;
    logic [CH_W-1:0]    cfg_ch;
    logic [CNT_W-1:0]   cfg_period;
    logic [CNT_W-1:0]   cfg_width;
    logic [BURST_W-1:0] cfg_burst_n;
    logic               cfg_burst;
    logic [NUM_CH-1:0]  start;
    logic [NUM_CH-1:0]  stop;
    logic [NUM_CH-1:0]  pulse_out;
    logic [NUM_CH-1:0]  busy;
    logic [NUM_CH-1:0]  done;

    multi_channel_pulse_generator #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .BURST_W(BURST_W),
        .CH_W   (CH_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_width  (cfg_width),
        .cfg_burst_n(cfg_burst_n),
        .cfg_burst  (cfg_burst),
        .start      (start),
        .stop       (stop),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    task automatic check(input string name, input logic [3*NUM_CH-1:0] act,
                         input logic [3*NUM_CH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: pulse/busy/done got %b required %b", name, act, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic               en;
        logic               we;
        logic [CH_W-1:0]    ch;
        logic [CNT_W-1:0]   p;
        logic [CNT_W-1:0]   w;
        logic [BURST_W-1:0] n;
        logic               b;
        logic [NUM_CH-1:0]  st;
        logic [NUM_CH-1:0]  sp;
        logic [NUM_CH-1:0]  ep;
        logic [NUM_CH-1:0]  eb;
        logic [NUM_CH-1:0]  ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic en, input logic we, input int ch, input int p,
                       input int w, input int n, input logic b,
                       input logic [NUM_CH-1:0] st, input logic [NUM_CH-1:0] sp,
                       input logic [NUM_CH-1:0] ep, input logic [NUM_CH-1:0] eb,
                       input logic [NUM_CH-1:0] ed);
        vec_t v;
        v.en = en; v.we = we; v.ch = CH_W'(ch);
        v.p = CNT_W'(p); v.w = CNT_W'(w); v.n = BURST_W'(n); v.b = b;
        v.st = st; v.sp = sp; v.ep = ep; v.eb = eb; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        enable = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_width = '0; cfg_burst_n = '0; cfg_burst = 1'b0; start = '0; stop = '0;
    endtask

    task automatic fill_table();
        // ch1 burst P=4 W=1 N=3: highs at 0,4,8; done on the 13th cycle
        add(1, 1, 1, 4, 1, 3, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k <= 13; k++)
            add(1, 0, 0, 0, 0, 0, 0, (k == 0) ? 3'b010 : 3'b000, 3'b000,
                (k < 12 && k % 4 == 0) ? 3'b010 : 3'b000,
                (k < 12) ? 3'b010 : 3'b000, (k == 12) ? 3'b010 : 3'b000);
        // ch0 continuous P=5 W=2, update to P=3 W=3 mid-period, then start+stop
        add(1, 1, 0, 5, 2, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k <= 21; k++)
            add(1, (k == 12), 0, 3, 3, 1, 0,
                (k == 0 || k == 20) ? 3'b001 : 3'b000, (k == 20) ? 3'b001 : 3'b000,
                ((k < 12 && k % 5 < 2) || (k >= 15 && k < 20)) ? 3'b001 : 3'b000,
                (k < 20) ? 3'b001 : 3'b000, 3'b000);
        // ch2 P=6 W=3, enable low for 4 cycles at c=1; stop ignored and a
        // config write accepted while disabled
        add(1, 1, 2, 6, 3, 1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k <= 14; k++)
            add(!(k >= 2 && k <= 5), (k == 4), 0, 0, 1, 0, 1,
                (k == 0) ? 3'b100 : 3'b000, (k == 3 || k == 14) ? 3'b100 : 3'b000,
                (k == 0 || k == 1 || k == 6 || k == 10 || k == 11 || k == 12) ? 3'b100 : 3'b000,
                (k < 14) ? 3'b100 : 3'b000, 3'b000);
        // ch0 now P=0,W=1,N=0 burst: behaves as a single 1-cycle period
        for (int k = 0; k <= 2; k++)
            add(1, 0, 0, 0, 0, 0, 0, (k == 0) ? 3'b001 : 3'b000, 3'b000,
                (k == 0) ? 3'b001 : 3'b000, (k == 0) ? 3'b001 : 3'b000,
                (k == 1) ? 3'b001 : 3'b000);
        // ch1 W=0 burst N=2 P=3: never high, done after 2*P cycles
        add(1, 1, 1, 3, 0, 2, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k <= 7; k++)
            add(1, 0, 0, 0, 0, 0, 0, (k == 0) ? 3'b010 : 3'b000, 3'b000, 3'b000,
                (k < 6) ? 3'b010 : 3'b000, (k == 6) ? 3'b010 : 3'b000);
        // write to cfg_ch=NUM_CH must touch nothing; all channels start together
        add(1, 1, 3, 2, 2, 5, 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k <= 8; k++)
            add(1, 0, 0, 0, 0, 0, 0, (k == 0) ? 3'b111 : 3'b000,
                (k == 8) ? 3'b111 : 3'b000,
                {(k % 6 < 3) && (k < 8), 1'b0, (k == 0)},
                {(k < 8), (k < 6), (k == 0)},
                {1'b0, (k == 6), (k == 1)});
        // ch1 burst P=2 W=1 N=2, retriggered at k=3: count restarts, no early done
        add(1, 1, 1, 2, 1, 2, 1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int k = 0; k <= 8; k++)
            add(1, 0, 0, 0, 0, 0, 0, (k == 0 || k == 3) ? 3'b010 : 3'b000, 3'b000,
                (k == 0 || k == 2 || k == 3 || k == 5) ? 3'b010 : 3'b000,
                (k < 7) ? 3'b010 : 3'b000, (k == 7) ? 3'b010 : 3'b000);
    endtask

    // ---------------- reference model ----------------
    // Each running channel holds how many high and low samples are left in
    // the current period; an empty period means a period boundary.
    int                sh_p [NUM_CH];
    int                sh_w [NUM_CH];
    int                sh_n [NUM_CH];
    bit                sh_b [NUM_CH];
    bit                m_run  [NUM_CH];
    bit                m_burst[NUM_CH];
    int                m_p    [NUM_CH];
    int                m_w    [NUM_CH];
    int                m_left [NUM_CH];
    int                hi_left[NUM_CH];
    int                lo_left[NUM_CH];
    logic [NUM_CH-1:0] exp_pulse, exp_busy, exp_done;

    function automatic int norm1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            sh_p[c] = 1; sh_w[c] = 0; sh_n[c] = 1; sh_b[c] = 0;
            m_run[c] = 0; m_burst[c] = 0; m_p[c] = 1; m_w[c] = 0; m_left[c] = 1;
            hi_left[c] = 0; lo_left[c] = 0;
        end
        exp_pulse = '0; exp_busy = '0; exp_done = '0;
    endtask

    task automatic new_period(input int c);
        hi_left[c] = (m_w[c] < m_p[c]) ? m_w[c] : m_p[c];
        lo_left[c] = m_p[c] - hi_left[c];
    endtask

    task automatic emit(input int c);
        if (hi_left[c] > 0) begin
            hi_left[c]--;
            exp_pulse[c] = 1'b1;
        end else begin
            lo_left[c]--;
            exp_pulse[c] = 1'b0;
        end
    endtask

    // Predicts the outputs after the coming edge from the current inputs.
    task automatic model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            exp_done[c] = 1'b0;
            if (!enable) begin
                exp_pulse[c] = 1'b0;
            end else if (stop[c]) begin
                m_run[c] = 0; exp_pulse[c] = 1'b0;
            end else if (start[c]) begin
                m_run[c] = 1; m_p[c] = norm1(sh_p[c]); m_w[c] = sh_w[c];
                m_burst[c] = sh_b[c]; m_left[c] = norm1(sh_n[c]);
                new_period(c); emit(c);
            end else if (m_run[c]) begin
                if (hi_left[c] == 0 && lo_left[c] == 0) begin
                    if (m_burst[c]) begin
                        m_left[c]--;
                        if (m_left[c] == 0) begin
                            m_run[c] = 0; exp_pulse[c] = 1'b0; exp_done[c] = 1'b1;
                        end else begin
                            new_period(c); emit(c);
                        end
                    end else begin
                        m_p[c] = norm1(sh_p[c]); m_w[c] = sh_w[c];
                        new_period(c); emit(c);
                    end
                end else begin
                    emit(c);
                end
            end else begin
                exp_pulse[c] = 1'b0;
            end
            exp_busy[c] = m_run[c];
        end
        if (cfg_we && int'(cfg_ch) < NUM_CH) begin
            sh_p[int'(cfg_ch)] = int'(cfg_period);
            sh_w[int'(cfg_ch)] = int'(cfg_width);
            sh_n[int'(cfg_ch)] = int'(cfg_burst_n);
            sh_b[int'(cfg_ch)] = cfg_burst;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic tick_check(input string name, input logic [3*NUM_CH-1:0] exp);
        @(posedge clk);
        #1;
        check(name, {pulse_out, busy, done}, exp);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", {pulse_out, busy, done}, '0);
        reset = 1'b0;

        // ---- table-driven vectors ----
        fill_table();
        for (int i = 0; i < tbl.size(); i++) begin
            enable      = tbl[i].en;
            cfg_we      = tbl[i].we;
            cfg_ch      = tbl[i].ch;
            cfg_period  = tbl[i].p;
            cfg_width   = tbl[i].w;
            cfg_burst_n = tbl[i].n;
            cfg_burst   = tbl[i].b;
            start       = tbl[i].st;
            stop        = tbl[i].sp;
            @(posedge clk);
            #1;
            check($sformatf("tbl[%0d]", i), {pulse_out, busy, done},
                  {tbl[i].ep, tbl[i].eb, tbl[i].ed});
        end
        idle_inputs();

        // ---- asynchronous reset in the middle of a run ----
        start = 3'b100;
        tick_check("rst_pre0", {3'b100, 3'b100, 3'b000});
        start = 3'b000;
        tick_check("rst_pre1", {3'b100, 3'b100, 3'b000});
        #2;
        reset = 1'b1;
        #1;
        check("rst_async", {pulse_out, busy, done}, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 8; k++)
            tick_check("rst_idle", '0);
        // shadow returned to P=1 W=0 continuous: busy but never high
        start = 3'b100;
        tick_check("rst_defcfg", {3'b000, 3'b100, 3'b000});
        start = 3'b000;
        for (int k = 0; k < 2; k++)
            tick_check("rst_defcfg_run", {3'b000, 3'b100, 3'b000});
        stop = 3'b100;
        tick_check("rst_defcfg_stop", '0);
        stop = 3'b000;

        // ---- randomized traffic against the model ----
        do_reset();
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            enable      = ($urandom_range(0, 9) != 0);
            cfg_we      = ($urandom_range(0, 4) == 0);
            cfg_ch      = CH_W'($urandom_range(0, 3));
            cfg_period  = CNT_W'($urandom_range(0, 9));
            cfg_width   = CNT_W'($urandom_range(0, 10));
            cfg_burst_n = BURST_W'($urandom_range(0, 4));
            cfg_burst   = 1'($urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++) begin
                start[c] = ($urandom_range(0, 11) == 0);
                stop[c]  = ($urandom_range(0, 29) == 0);
            end
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("rand[%0d]", k), {pulse_out, busy, done},
                  {exp_pulse, exp_busy, exp_done});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
